// File: rtl/pipe_fetch_decode_skid.sv
// Fetch-to-decode pipeline register with valid/ready handshake, a one-deep skid
// entry behind the main entry, and synchronous flush. in_ready is flop-driven.
module pipe_fetch_decode_skid #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     ILEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] instr_f,
    input  logic [XLEN-1:0] pc_f,
    input  logic [XLEN-1:0] pc_plus_4_f,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus_4_d
);

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus_4;
    } entry_t;

    // State bits are the entry valid bits: bit0 = main valid, bit1 = skid valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b11
    } state_e;

    localparam entry_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus_4: '0};

    state_e r_state;
    entry_t r_main;
    entry_t r_skid;
    entry_t w_in;

    assign w_in = '{instr: instr_f, pc: pc_f, pc_plus_4: pc_plus_4_f};

    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_state <= ST_EMPTY;
            // NOTE: data registers are reset too, because the main entry drives
            // the decode outputs directly and must read as a bubble.
            r_main  <= BUBBLE;
            r_skid  <= BUBBLE;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        r_main  <= w_in;
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_valid && out_ready) begin
                        r_main <= w_in;
                    end else if (out_ready) begin
                        r_main  <= BUBBLE;
                        r_state <= ST_EMPTY;
                    end else if (in_valid) begin
                        r_skid  <= w_in;
                        r_state <= ST_SKID;
                    end
                end
                ST_SKID: begin
                    // in_valid is ignored here: in_ready is low in this state.
                    if (out_ready) begin
                        r_main  <= r_skid;
                        r_skid  <= BUBBLE;
                        r_state <= ST_FULL;
                    end
                end
                default: begin
                    r_main  <= BUBBLE;
                    r_skid  <= BUBBLE;
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    assign out_valid   = r_state[0];
    assign in_ready    = ~r_state[1];
    assign instr_d     = r_main.instr;
    assign pc_d        = r_main.pc;
    assign pc_plus_4_d = r_main.pc_plus_4;

endmodule
